reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Sits directly downstream of the operand comparator/issue stage.
- Buffers issued instructions whose source operands may still be pending, and snoops both CDB channels to wake those operands up.
- Dispatches one fully-ready instruction per cycle to its execution unit.
- Holds up to ENTRIES instructions; per-entry state is fully registered.

Parameters:
ENTRIES, 4, number of instruction slots (power of two, >=2)
XLEN, 32, operand/result/address width
TAG_W, 6, renamed-register tag width (rrn); tag 0 reserved and never matches
OP_W, 16, opaque packed instruction name/type/flags payload width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
flush  in  1  drop all entries (branch mispredict)
issue_valid  in  1  issue packet present
issue_ready  out  1  slot available
issue_op  in  OP_W  instruction payload
issue_address  in  XLEN  instruction address
issue_immediate  in  XLEN  immediate
issue_rd  in  TAG_W  destination tag
issue_tag_1 / issue_tag_2  in  TAG_W  source tags (rs_1/rs_2)
issue_data_1 / issue_data_2  in  XLEN  source values
issue_valid_1 / issue_valid_2  in  1  source value already valid
cdb_valid[0:1]  in  1 each  CDB channel carries a result
cdb_rrn[0:1]  in  TAG_W each  producing tag
cdb_result[0:1]  in  XLEN each  result value
disp_valid  out  1  a ready entry is presented
disp_ready  in  1  execution unit accepts
disp_op, disp_address, disp_immediate, disp_rd  out  as issue_*  selected entry fields
disp_data_1 / disp_data_2  out  XLEN  operand values

Behaviour:
- Reset (reset_n=0 at clk edge): all entry busy/ready bits cleared.
  - issue_ready=0 and disp_valid=0 while reset_n is low.
  - All disp_* data outputs are 0 while no entry is selected.
- issue_ready = (busy count < ENTRIES), from registered state only.
  - An issue is not accepted into a slot freed by a dispatch in the same cycle.
- Allocation: issue_valid&issue_ready writes the lowest-index free slot and sets busy.
  - Per operand, stored ready = issue_valid_n OR (tag_n!=0 AND a CDB channel matches tag_n this cycle).
  - Stored data = the CDB result on a match, else issue_data_n.
- Wakeup: every cycle, each busy entry with a not-ready operand whose tag!=0 and equals cdb_rrn[k] with cdb_valid[k] captures cdb_result[k] and sets ready.
  - If both channels match the same tag, channel 0 wins.
- An entry is eligible for dispatch when busy and both operands are ready (registered).
  - Wakeup in cycle N therefore gives the earliest dispatch in cycle N+1.
- Selection: the lowest-index eligible entry; disp_valid=1 iff any entry is eligible.
  - disp_* are combinational from the selected entry.
  - The selection must stay stable while disp_valid&!disp_ready, unless flush or reset intervenes.
- Dispatch: disp_valid&disp_ready clears that entry's busy bit at the clock edge.
- Simultaneous events:
  - Issue, wakeup and dispatch in one cycle act on distinct slots; all take effect.
  - Flush has priority over issue, wakeup and dispatch: all busy bits clear next edge and the incoming issue is dropped.
  - A dispatch handshaked in the flush cycle still counts as delivered.
- Full: issue_ready=0 and issue_valid is ignored; no state change from the issue port.
- Empty: disp_valid=0.
- Reset asserted mid-operation discards all entries identically to flush.

Optional Feature:
- RS_OLDEST_FIRST_EN defined:
  - Each allocation stamps the entry with a wrap-around sequence counter ($clog2(ENTRIES)+1 bits).
  - Selection picks the eligible entry with the oldest stamp, compared modulo relative to the oldest busy entry.
  - The counter resets to 0 and also clears on flush.
- Not defined:
  - Lowest-index selection as above.
  - No stamp storage.

Test Plan:
- Reset, then issue op with valid_1=valid_2=1, data 5/7, rd=3, disp_ready=1 -> disp_valid next cycle with data 5/7, rd 3; then empty, issue_ready=1.
- Issue tag_1=9 not valid; two cycles later cdb_valid[1]=1, rrn=9, result 0x1234 -> disp_valid exactly one cycle after the CDB cycle, disp_data_1=0x1234.
- Issue tag_2=4 not valid while cdb[0] rrn=4 result 0xAA in the same cycle -> captured at allocation, dispatch next cycle with data_2=0xAA; both CDB channels rrn=4 (0x11/0x22) -> 0x11 captured.
- Fill all 4 slots with pending operands -> issue_ready=0, a fifth issue is ignored; wake slot 2 and dispatch it -> issue_ready=1 the following cycle.
- disp_ready=0 for 3 cycles with two eligible entries -> disp_* held on the same entry throughout; flush -> disp_valid=0 and issue_ready=1 next cycle.
- With RS_OLDEST_FIRST_EN: allocate A(slot0, pending), B(slot1, ready), dispatch B, allocate C(slot1, ready), wake A -> A dispatched before C.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: CDB-snooping instruction buffer dispatching one ready entry per cycle (define RS_OLDEST_FIRST_EN for oldest-first selection)
module reservation_station #(
  parameter int ENTRIES = 4,
  parameter int XLEN = 32,
  parameter int TAG_W = 6,
  parameter int OP_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_address,
  input  logic [XLEN-1:0]  issue_immediate,
  input  logic [TAG_W-1:0] issue_rd,
  input  logic [TAG_W-1:0] issue_tag_1,
  input  logic [TAG_W-1:0] issue_tag_2,
  input  logic [XLEN-1:0]  issue_data_1,
  input  logic [XLEN-1:0]  issue_data_2,
  input  logic             issue_valid_1,
  input  logic             issue_valid_2,
  input  logic             cdb_valid [2],
  input  logic [TAG_W-1:0] cdb_rrn [2],
  input  logic [XLEN-1:0]  cdb_result [2],
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [OP_W-1:0]  disp_op,
  output logic [XLEN-1:0]  disp_address,
  output logic [XLEN-1:0]  disp_immediate,
  output logic [TAG_W-1:0] disp_rd,
  output logic [XLEN-1:0]  disp_data_1,
  output logic [XLEN-1:0]  disp_data_2
);
  localparam int IW = $clog2(ENTRIES);
  logic [ENTRIES-1:0] busy, rdy1, rdy2, elig;
  logic [TAG_W-1:0] tag1 [ENTRIES];
  logic [TAG_W-1:0] tag2 [ENTRIES];
  logic [TAG_W-1:0] rd [ENTRIES];
  logic [XLEN-1:0] data1 [ENTRIES];
  logic [XLEN-1:0] data2 [ENTRIES];
  logic [XLEN-1:0] addr [ENTRIES];
  logic [XLEN-1:0] imm [ENTRIES];
  logic [OP_W-1:0] op [ENTRIES];
  logic [IW-1:0] free_idx, pick, sel, held_idx;
  logic held_v, alloc, fire;
`ifdef RS_OLDEST_FIRST_EN
  localparam int SW = IW + 1;
  logic [SW-1:0] seq, best, age;
  logic [SW-1:0] stamp [ENTRIES];
`endif
  function automatic logic [XLEN:0] snoop(input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    logic [XLEN:0] r;
    r = {v, d};
    if (!v && t != '0) begin
      if (cdb_valid[1] && cdb_rrn[1] == t) r = {1'b1, cdb_result[1]};
      if (cdb_valid[0] && cdb_rrn[0] == t) r = {1'b1, cdb_result[0]};
    end
    return r;
  endfunction
  always_comb begin
    elig = busy & rdy1 & rdy2;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) if (!busy[i]) free_idx = IW'(i);
    pick = '0;
`ifdef RS_OLDEST_FIRST_EN
    best = '0;
    age = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      age = seq - stamp[i];
      if (elig[i] && age > best) begin
        best = age;
        pick = IW'(i);
      end
    end
`else
    for (int i = ENTRIES - 1; i >= 0; i--) if (elig[i]) pick = IW'(i);
`endif
  end
  // A stalled handshake pins its entry so later wakeups cannot reorder the offer.
  assign sel = held_v ? held_idx : pick;
  assign issue_ready = reset_n & ~&busy;
  assign alloc = issue_valid & issue_ready;
  assign disp_valid = reset_n & |elig;
  assign fire = disp_valid & disp_ready;
  assign disp_op = disp_valid ? op[sel] : '0;
  assign disp_address = disp_valid ? addr[sel] : '0;
  assign disp_immediate = disp_valid ? imm[sel] : '0;
  assign disp_rd = disp_valid ? rd[sel] : '0;
  assign disp_data_1 = disp_valid ? data1[sel] : '0;
  assign disp_data_2 = disp_valid ? data2[sel] : '0;
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      busy <= '0;
      held_v <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
      seq <= '0;
`endif
    end else begin
      held_v <= disp_valid & ~disp_ready;
      held_idx <= sel;
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i]) begin
          {rdy1[i], data1[i]} <= snoop(rdy1[i], tag1[i], data1[i]);
          {rdy2[i], data2[i]} <= snoop(rdy2[i], tag2[i], data2[i]);
        end
      end
      if (fire) busy[sel] <= 1'b0;
      if (alloc) begin
        busy[free_idx] <= 1'b1;
        tag1[free_idx] <= issue_tag_1;
        tag2[free_idx] <= issue_tag_2;
        {rdy1[free_idx], data1[free_idx]} <= snoop(issue_valid_1, issue_tag_1, issue_data_1);
        {rdy2[free_idx], data2[free_idx]} <= snoop(issue_valid_2, issue_tag_2, issue_data_2);
        op[free_idx] <= issue_op;
        addr[free_idx] <= issue_address;
        imm[free_idx] <= issue_immediate;
        rd[free_idx] <= issue_rd;
`ifdef RS_OLDEST_FIRST_EN
        stamp[free_idx] <= seq;
        seq <= seq + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vector bench for reservation_station
module tb_reservation_station;
  logic clk, reset_n, flush, issue_valid, issue_ready, issue_valid_1, issue_valid_2;
  logic disp_valid, disp_ready;
  logic [15:0] issue_op, disp_op;
  logic [31:0] issue_address, issue_immediate, issue_data_1, issue_data_2;
  logic [31:0] disp_address, disp_immediate, disp_data_1, disp_data_2;
  logic [5:0] issue_rd, issue_tag_1, issue_tag_2, disp_rd;
  logic cdb_valid [2];
  logic [5:0] cdb_rrn [2];
  logic [31:0] cdb_result [2];
  int checks = 0;
  int failures = 0;
  int step_no = 0;
  typedef struct {
    logic rst_n, fl, iv;
    logic [5:0] t1;
    logic v1;
    logic [31:0] d1;
    logic [5:0] t2;
    logic v2;
    logic [31:0] d2;
    logic [5:0] rd;
    logic cv0;
    logic [5:0] r0;
    logic [31:0] x0;
    logic cv1;
    logic [5:0] r1;
    logic [31:0] x1;
    logic dr, eir, edv;
    logic [31:0] ed1, ed2;
    logic [5:0] erd;
  } vec_t;
  vec_t tbl [20];
  reservation_station dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_address(issue_address), .issue_immediate(issue_immediate), .issue_rd(issue_rd),
    .issue_tag_1(issue_tag_1), .issue_tag_2(issue_tag_2),
    .issue_data_1(issue_data_1), .issue_data_2(issue_data_2),
    .issue_valid_1(issue_valid_1), .issue_valid_2(issue_valid_2),
    .cdb_valid(cdb_valid), .cdb_rrn(cdb_rrn), .cdb_result(cdb_result),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_address(disp_address), .disp_immediate(disp_immediate), .disp_rd(disp_rd),
    .disp_data_1(disp_data_1), .disp_data_2(disp_data_2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(
    input logic [31:0] rst_n, fl, iv, t1, v1, d1, t2, v2, d2, rd,
    input logic [31:0] cv0, r0, x0, cv1, r1, x1, dr, eir, edv, ed1, ed2, erd);
    vec_t m;
    m.rst_n = rst_n[0]; m.fl = fl[0]; m.iv = iv[0];
    m.t1 = t1[5:0]; m.v1 = v1[0]; m.d1 = d1;
    m.t2 = t2[5:0]; m.v2 = v2[0]; m.d2 = d2; m.rd = rd[5:0];
    m.cv0 = cv0[0]; m.r0 = r0[5:0]; m.x0 = x0;
    m.cv1 = cv1[0]; m.r1 = r1[5:0]; m.x1 = x1;
    m.dr = dr[0]; m.eir = eir[0]; m.edv = edv[0];
    m.ed1 = ed1; m.ed2 = ed2; m.erd = erd[5:0];
    return m;
  endfunction
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
    end
  endtask
  task automatic step(input vec_t v);
    logic [79:0] meta;
    reset_n = v.rst_n; flush = v.fl; issue_valid = v.iv;
    issue_tag_1 = v.t1; issue_valid_1 = v.v1; issue_data_1 = v.d1;
    issue_tag_2 = v.t2; issue_valid_2 = v.v2; issue_data_2 = v.d2;
    issue_rd = v.rd;
    issue_op = 16'hA500 | {10'd0, v.rd};
    issue_address = {24'd0, v.rd, 2'b00};
    issue_immediate = 32'h1000 + {26'd0, v.rd};
    cdb_valid[0] = v.cv0; cdb_rrn[0] = v.r0; cdb_result[0] = v.x0;
    cdb_valid[1] = v.cv1; cdb_rrn[1] = v.r1; cdb_result[1] = v.x1;
    disp_ready = v.dr;
    meta = v.edv ? {16'hA500 | {10'd0, v.erd}, 24'd0, v.erd, 2'b00, 32'h1000 + {26'd0, v.erd}} : '0;
    #1;
    chk("issue_ready", {79'd0, issue_ready}, {79'd0, v.eir});
    chk("disp_valid", {79'd0, disp_valid}, {79'd0, v.edv});
    chk("disp_data_1", {48'd0, disp_data_1}, {48'd0, v.edv ? v.ed1 : 32'd0});
    chk("disp_data_2", {48'd0, disp_data_2}, {48'd0, v.edv ? v.ed2 : 32'd0});
    chk("disp_rd", {74'd0, disp_rd}, {74'd0, v.edv ? v.erd : 6'd0});
    chk("disp_op_addr_imm", {disp_op, disp_address, disp_immediate}, meta);
    step_no++;
    @(negedge clk);
  endtask
  initial begin
    //            rst fl iv t1 v1 d1 t2 v2 d2 rd  cv0 r0 x0  cv1 r1 x1 dr  ir dv ed1 ed2 erd
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 1, 5, 0, 1, 7, 3,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 5, 7, 3);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 9, 0, 0, 0, 1, 2, 5,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 9, 'h1234, 1,  1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 'h1234, 2, 5);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 1, 4, 0, 0, 6,  1, 4, 'hAA, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 1, 'hAA, 6);
    tbl[12] = mk(1, 0, 1, 7, 0, 0, 0, 1, 3, 8,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 7, 'h11, 1, 7, 'h22, 1,  1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 'h11, 3, 8);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 9,  1, 0, 'h55, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h55, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(tbl[i]);
    // fill all slots with pending operands, fifth issue must be dropped
    for (int i = 0; i < 4; i++) step(mk(1, 0, 1, 10 + i, 0, 0, 0, 1, 0, 20 + i, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, 0, 1, 0, 1, 'h99, 0, 1, 0, 30, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'h22, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h22, 0, 22));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // stall with slots 1 and 3 eligible, then slot 0 wakes; offer must stay on slot 1
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 'h33, 1, 11, 'h31, 0, 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 0, 21));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 'h30, 0, 0, 0, 0, 1, 1, 'h31, 0, 21));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 0, 21));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 0, 21));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // A pending in slot 0, B dispatched, C reuses slot 1, A woken: A goes first
    step(mk(1, 0, 1, 40, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, 0, 1, 0, 1, 'h0B, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h0B, 0, 2));
    step(mk(1, 0, 1, 0, 1, 'h0C, 0, 1, 0, 3, 1, 40, 'h77, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h77, 0, 1));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h0C, 0, 3));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // reset mid-operation discards a ready entry
    step(mk(1, 0, 1, 0, 1, 'h44, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
